// File: rtl/multicycle_control_unit_if.sv
// Interface bundling the control unit's handshake inputs and datapath control outputs.
//
// Parameters:
//   COUNT_W    width of the retired-instruction counter
//
// Signals:
//   en, opcode, mem_ready              inputs to the control unit
//   alu_op .. reg_write                datapath enables and mux selects
//   illegal_op, state_out              decode error flag and debug state
//   instr_count                        retired-instruction count (zero unless counter is built)
//
// Modports:
//   master  the control unit (drives controls, samples en/opcode/mem_ready)
//   slave   the environment (instruction register, memory, datapath)
interface multicycle_control_unit_if #(
    parameter int unsigned COUNT_W = 32
);
    logic               en;
    logic [5:0]         opcode;
    logic               mem_ready;
    logic [1:0]         alu_op;
    logic               alu_src_a;
    logic [1:0]         alu_src_b;
    logic [1:0]         pc_source;
    logic               pc_write;
    logic               pc_write_cond;
    logic               i_or_d;
    logic               mem_read;
    logic               mem_write;
    logic               ir_write;
    logic               mem_to_reg;
    logic               reg_dst;
    logic               reg_write;
    logic               illegal_op;
    logic [3:0]         state_out;
    logic [COUNT_W-1:0] instr_count;

    modport master (
        input  en, opcode, mem_ready,
        output alu_op, alu_src_a, alu_src_b, pc_source, pc_write, pc_write_cond,
               i_or_d, mem_read, mem_write, ir_write, mem_to_reg, reg_dst, reg_write,
               illegal_op, state_out, instr_count
    );

    modport slave (
        output en, opcode, mem_ready,
        input  alu_op, alu_src_a, alu_src_b, pc_source, pc_write, pc_write_cond,
               i_or_d, mem_read, mem_write, ir_write, mem_to_reg, reg_dst, reg_write,
               illegal_op, state_out, instr_count
    );
endinterface

// File: rtl/multicycle_control_unit.sv
// Main control FSM for the multicycle MIPS datapath. Walks each instruction through
// fetch/decode/execute/memory/writeback and drives every datapath enable and mux select.
// Outputs are Moore-decoded from the state, except ir_write/pc_write in FETCH which are
// gated by mem_ready.
//
// Ports:
//   clk   system clock, rising edge
//   rst   asynchronous active-high reset, forces IDLE
//   bus   multicycle_control_unit_if.master (en, opcode, mem_ready in; controls out)
//
// Build option:
//   MCCU_INSTR_COUNT_EN  when defined, builds a COUNT_W-bit retired-instruction counter
//                        on bus.instr_count; otherwise bus.instr_count is tied to zero.
module multicycle_control_unit #(
    parameter int unsigned COUNT_W = 32
) (
    input logic                        clk,
    input logic                        rst,
    multicycle_control_unit_if.master  bus
);

    typedef enum logic [3:0] {
        StIdle     = 4'd0,
        StFetch    = 4'd1,
        StDecode   = 4'd2,
        StMemAddr  = 4'd3,
        StMemRead  = 4'd4,
        StMemWb    = 4'd5,
        StMemWrite = 4'd6,
        StRExec    = 4'd7,
        StRWb      = 4'd8,
        StBranch   = 4'd9,
        StJump     = 4'd10,
        StAddiExec = 4'd11,
        StAddiWb   = 4'd12
    } state_t;

    localparam logic [5:0] OpRType = 6'b000000;
    localparam logic [5:0] OpJ     = 6'b000010;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;

    state_t state_q, state_d;
    logic   done;    // instruction finishes this cycle
    logic   retire;  // finishing instruction counts as retired

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d           = state_q;
        done              = 1'b0;
        retire            = 1'b0;
        bus.alu_op        = 2'b00;
        bus.alu_src_a     = 1'b0;
        bus.alu_src_b     = 2'b00;
        bus.pc_source     = 2'b00;
        bus.pc_write      = 1'b0;
        bus.pc_write_cond = 1'b0;
        bus.i_or_d        = 1'b0;
        bus.mem_read      = 1'b0;
        bus.mem_write     = 1'b0;
        bus.ir_write      = 1'b0;
        bus.mem_to_reg    = 1'b0;
        bus.reg_dst       = 1'b0;
        bus.reg_write     = 1'b0;
        bus.illegal_op    = 1'b0;

        case (state_q)
            StIdle: begin
                if (bus.en) begin
                    state_d = StFetch;
                end
            end
            StFetch: begin
                // PC <= PC + 4 and IR load happen together, only once memory delivers.
                bus.mem_read  = 1'b1;
                bus.alu_src_b = 2'b01;
                bus.ir_write  = bus.mem_ready;
                bus.pc_write  = bus.mem_ready;
                if (bus.mem_ready) begin
                    state_d = StDecode;
                end
            end
            StDecode: begin
                // Branch target precomputed into ALUOut while the opcode is decoded.
                bus.alu_src_b = 2'b11;
                case (bus.opcode)
                    OpLw, OpSw: state_d = StMemAddr;
                    OpRType:    state_d = StRExec;
                    OpBeq:      state_d = StBranch;
                    OpJ:        state_d = StJump;
                    OpAddi:     state_d = StAddiExec;
                    default: begin
                        bus.illegal_op = 1'b1;
                        done           = 1'b1;
                    end
                endcase
            end
            StMemAddr: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'b10;
                state_d       = (bus.opcode == OpSw) ? StMemWrite : StMemRead;
            end
            StMemRead: begin
                bus.mem_read = 1'b1;
                bus.i_or_d   = 1'b1;
                if (bus.mem_ready) begin
                    state_d = StMemWb;
                end
            end
            StMemWb: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = 1'b1;
                done           = 1'b1;
                retire         = 1'b1;
            end
            StMemWrite: begin
                bus.mem_write = 1'b1;
                bus.i_or_d    = 1'b1;
                done          = bus.mem_ready;
                retire        = bus.mem_ready;
            end
            StRExec: begin
                bus.alu_src_a = 1'b1;
                bus.alu_op    = 2'b10;
                state_d       = StRWb;
            end
            StRWb: begin
                bus.reg_write = 1'b1;
                bus.reg_dst   = 1'b1;
                done          = 1'b1;
                retire        = 1'b1;
            end
            StBranch: begin
                bus.alu_src_a     = 1'b1;
                bus.alu_op        = 2'b01;
                bus.pc_write_cond = 1'b1;
                bus.pc_source     = 2'b01;
                done              = 1'b1;
                retire            = 1'b1;
            end
            StJump: begin
                bus.pc_write  = 1'b1;
                bus.pc_source = 2'b10;
                done          = 1'b1;
                retire        = 1'b1;
            end
            StAddiExec: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'b10;
                state_d       = StAddiWb;
            end
            StAddiWb: begin
                bus.reg_write = 1'b1;
                done          = 1'b1;
                retire        = 1'b1;
            end
            // Unused codes 13..15 recover to IDLE with all controls low.
            default: state_d = StIdle;
        endcase

        // en only gates the start of the next instruction, never the current one.
        if (done) begin
            state_d = bus.en ? StFetch : StIdle;
        end
    end

    assign bus.state_out = state_q;

`ifdef MCCU_INSTR_COUNT_EN
    logic [COUNT_W-1:0] count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (retire) begin
            count_q <= count_q + COUNT_W'(1);
        end
    end

    assign bus.instr_count = count_q;
`else
    logic unused_retire;
    assign unused_retire   = retire;
    assign bus.instr_count = {COUNT_W{1'b0}};
`endif

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Main control FSM for the multicycle MIPS datapath.
- Decodes the 6-bit instruction opcode across fetch/decode/execute/memory/writeback states.
- Drives every datapath enable and mux select, including the 2-bit alu_op consumed by the ALU control decoder.
- Sits between the instruction register and the datapath; handshakes with memory through mem_ready.

Parameters:
- COUNT_W, 32, width of the retired-instruction counter (optional feature only).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  run enable; FSM leaves IDLE and starts new instructions only while high.
- opcode  input  6  instruction[31:26] from the instruction register.
- mem_ready  input  1  memory completes the current read/write this cycle.
- alu_op  output  2  00 add, 01 subtract, 10 use funct field; 11 is never driven.
- alu_src_a  output  1  0 PC, 1 register A.
- alu_src_b  output  2  00 register B, 01 constant 4, 10 sign-extended imm, 11 imm<<2.
- pc_source  output  2  00 ALU result, 01 ALUOut, 10 jump target.
- pc_write  output  1  unconditional PC load.
- pc_write_cond  output  1  PC load if ALU zero.
- i_or_d  output  1  memory address: 0 PC, 1 ALUOut.
- mem_read  output  1  memory read request.
- mem_write  output  1  memory write request.
- ir_write  output  1  instruction register load.
- mem_to_reg  output  1  write-back data: 0 ALUOut, 1 MDR.
- reg_dst  output  1  destination register: 0 rt, 1 rd.
- reg_write  output  1  register file write.
- illegal_op  output  1  unknown opcode seen in DECODE.
- state_out  output  4  current state encoding, for debug.
- instr_count  output  COUNT_W  retired instructions (optional feature).

Behaviour:
- State register is 4 bits, encoded: IDLE 0, FETCH 1, DECODE 2, MEM_ADDR 3, MEM_READ 4, MEM_WB 5, MEM_WRITE 6, R_EXEC 7, R_WB 8, BRANCH 9, JUMP 10, ADDI_EXEC 11, ADDI_WB 12. Codes 13–15 go to IDLE on the next edge.
- rst (asynchronous) forces IDLE. Every output is 0 while in IDLE, including instr_count cleared. Reset mid-instruction aborts it with no further writes.
- Outputs are decoded combinationally from state (Moore), except the mem_ready gating noted below. Any signal not listed for a state is 0.
- IDLE: go to FETCH when en=1, otherwise stay.
- FETCH:
  - Drives mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
  - ir_write and pc_write are high only in the cycle mem_ready=1.
  - Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00. Opcode is sampled this cycle:
  - 100011 (lw) or 101011 (sw) -> MEM_ADDR
  - 000000 (R-type) -> R_EXEC
  - 000100 (beq) -> BRANCH
  - 000010 (j) -> JUMP
  - 001000 (addi) -> ADDI_EXEC
  - any other opcode -> illegal_op=1 this cycle, then the completion transition; it does not count as retired.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00. Next state is MEM_READ for lw, MEM_WRITE for sw; the opcode is re-read here and is stable.
- MEM_READ: mem_read=1, i_or_d=1. Waits for mem_ready, then MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0. Completion.
- MEM_WRITE: mem_write=1, i_or_d=1. Waits for mem_ready, then completion.
- R_EXEC: alu_src_a=1, alu_src_b=00, alu_op=10. Next state R_WB.
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0. Completion.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01. Completion.
- JUMP: pc_write=1, pc_source=10. Completion.
- ADDI_EXEC: alu_src_a=1, alu_src_b=10, alu_op=00. Next state ADDI_WB.
- ADDI_WB: reg_write=1, reg_dst=0, mem_to_reg=0. Completion.
- Completion transition: to FETCH if en=1, else IDLE. en=0 never aborts an instruction already in flight.
- Latency with mem_ready tied high:
  - R-type and addi: 4 cycles
  - lw: 5 cycles
  - sw: 4 cycles
  - beq and j: 3 cycles
- mem_read and mem_write are never high in the same cycle.

Optional Feature:
- MCCU_INSTR_COUNT_EN defined:
  - instr_count increments by 1 on each completion transition, except the illegal-opcode exit.
  - Wraps modulo 2^COUNT_W.
  - Cleared asynchronously by rst.
- Not defined: instr_count is tied to 0 and no counter logic is built.

Test Plan:
- rst=1 mid-MEM_READ, then release with en=1 -> all outputs 0 during reset; state_out 0 then 1; mem_write never asserted.
- en=1, mem_ready=1, opcode=000000 -> state_out sequence 1,2,7,8,1; alu_op=10 in R_EXEC; reg_write=1 and reg_dst=1 in R_WB only.
- lw (100011), mem_ready low 3 cycles in MEM_READ -> FSM holds state 4 for 3 cycles with mem_read=1, i_or_d=1; then 5 with mem_to_reg=1; total 8 cycles.
- beq (000100) -> BRANCH has alu_op=01, pc_write_cond=1, pc_source=01; back in FETCH after 3 cycles.
- opcode=111111 -> illegal_op=1 for exactly one cycle in DECODE; next state 1; instr_count unchanged (macro defined).
- en dropped during R_EXEC -> R_WB completes with reg_write=1, then state 0 with all outputs 0; with macro, instr_count=1 after 1 R-type, wraps to 0 after 2^COUNT_W retirements (COUNT_W=4 build, 16 instructions).
